// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with one 32-bit word per line.
// Misses are filled through a single MMU read port using a level-held req/ack handshake.
module icache_direct #(
  parameter int unsigned INDEX_L = 6,
  parameter int unsigned ADDR_L  = 32,
  parameter int unsigned DATA_L  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_re,
  input  logic [ADDR_L-1:0] f_addr,
  output logic [DATA_L-1:0] f_dout,
  output logic              f_rack,
  input  logic              flush,
  output logic              c_re,
  output logic [ADDR_L-1:0] c_raddr,
  output logic [1:0]        c_rlen,
  input  logic [DATA_L-1:0] c_din,
  input  logic              c_rack
);

  localparam int unsigned Lines = 1 << INDEX_L;
  localparam int unsigned TagL  = ADDR_L - INDEX_L - 2;

  typedef enum logic [2:0] {
    StIdle,
    StHitAck,
    StFill,
    StDrain,
    StMissAck
  } state_e;

  state_e              r_state, w_state_nxt;
  logic                r_f_rack, w_f_rack_nxt;
  logic [DATA_L-1:0]   r_f_dout, w_f_dout_nxt;
  logic                r_c_re, w_c_re_nxt;
  logic [ADDR_L-1:0]   r_c_raddr, w_c_raddr_nxt;
  logic                r_flush_pend, w_flush_pend_nxt;
  logic                r_abort, w_abort_nxt;
  logic [Lines-1:0]    r_valid;
  logic [DATA_L-1:0]   r_data [Lines];
  logic [TagL-1:0]     r_tag  [Lines];

  logic [INDEX_L-1:0]  w_idx;
  logic [TagL-1:0]     w_tag;
  logic [INDEX_L-1:0]  w_fill_idx;
  logic [TagL-1:0]     w_fill_tag;
  logic                w_hit;
  logic                w_fill_we;
  logic                w_unused;

  assign w_idx      = f_addr[INDEX_L+1:2];
  assign w_tag      = f_addr[ADDR_L-1:INDEX_L+2];
  // The latched miss address doubles as the fill target.
  assign w_fill_idx = r_c_raddr[INDEX_L+1:2];
  assign w_fill_tag = r_c_raddr[ADDR_L-1:INDEX_L+2];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused   = ^f_addr[1:0];

  assign f_dout  = r_f_dout;
  assign f_rack  = r_f_rack;
  assign c_re    = r_c_re;
  assign c_raddr = r_c_raddr;
  assign c_rlen  = 2'b11;

  always_comb begin
    w_state_nxt      = r_state;
    w_f_rack_nxt     = r_f_rack;
    w_f_dout_nxt     = r_f_dout;
    w_c_re_nxt       = r_c_re;
    w_c_raddr_nxt    = r_c_raddr;
    w_flush_pend_nxt = r_flush_pend;
    w_abort_nxt      = r_abort;
    w_fill_we        = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_flush_pend_nxt = 1'b0;
        w_abort_nxt      = 1'b0;
        if (f_re) begin
          if (w_hit) begin
            w_f_dout_nxt = r_data[w_idx];
            w_f_rack_nxt = 1'b1;
            w_state_nxt  = StHitAck;
          end else begin
            w_c_raddr_nxt = {f_addr[ADDR_L-1:2], 2'b00};
            w_c_re_nxt    = 1'b1;
            w_state_nxt   = StFill;
          end
        end
      end
      StHitAck, StMissAck: begin
        if (!f_re) begin
          w_f_rack_nxt = 1'b0;
          w_state_nxt  = StIdle;
        end
      end
      StFill: begin
        if (flush) w_flush_pend_nxt = 1'b1;
        if (!f_re) w_abort_nxt = 1'b1;
        if (c_rack) begin
          w_fill_we    = 1'b1;
          w_f_dout_nxt = c_din;
          w_c_re_nxt   = 1'b0;
          w_state_nxt  = StDrain;
        end
      end
      StDrain: begin
        if (flush) w_flush_pend_nxt = 1'b1;
        if (!f_re) w_abort_nxt = 1'b1;
        // Waiting for the MMU to drop its ack keeps the next c_re edge clean.
        if (!c_rack) begin
          if (f_re && !r_abort) begin
            w_f_rack_nxt = 1'b1;
            w_state_nxt  = StMissAck;
          end else begin
            w_state_nxt = StIdle;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_f_rack     <= 1'b0;
      r_f_dout     <= '0;
      r_c_re       <= 1'b0;
      r_c_raddr    <= '0;
      r_flush_pend <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_f_rack     <= w_f_rack_nxt;
      r_f_dout     <= w_f_dout_nxt;
      r_c_re       <= w_c_re_nxt;
      r_c_raddr    <= w_c_raddr_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      r_abort      <= w_abort_nxt;
    end
  end

  // Flush wins over a fill landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid <= '0;
    end else if (w_fill_we && !r_flush_pend) begin
      r_valid[w_fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_fill_we) begin
      r_data[w_fill_idx] <= c_din;
      r_tag[w_fill_idx]  <= w_fill_tag;
    end
  end

endmodule
